// File: rtl/add_sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_arbiter
//  Purpose  : Round-robin arbiter that shares one WIDTH-bit add/subtract unit
//             between NREQ requesters. The winning operation is computed into
//             a registered output stage with valid/ready handshaking.
//  Ports    :
//    CLK           in   clock, all state updates on the rising edge
//    RESET         in   synchronous active-high reset
//    REQ           in   [NREQ]        pending-operation flags
//    SUB_ADD       in   [NREQ]        per requester: 0 = A+B, 1 = A-B
//    IN_A, IN_B    in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//    GNT           out  [NREQ]        one-hot accept strobe (combinational)
//    RESULT        out  [WIDTH]       registered sum/difference
//    UNDER_OVER    out                carry (add) or borrow (sub)
//    RESULT_ID     out  [IDW]         requester that produced RESULT
//    RESULT_VALID  out                output stage holds an unconsumed result
//    RESULT_READY  in                 consumer takes the result this cycle
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ-1:0]       SUB_ADD,
    input  logic [NREQ*WIDTH-1:0] IN_A,
    input  logic [NREQ*WIDTH-1:0] IN_B,
    output logic [NREQ-1:0]       GNT,
    output logic [WIDTH-1:0]      RESULT,
    output logic                  UNDER_OVER,
    output logic [IDW-1:0]        RESULT_ID,
    output logic                  RESULT_VALID,
    input  logic                  RESULT_READY
);

    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_result;
    logic             r_under_over;
    logic [IDW-1:0]   r_result_id;
    logic             r_valid;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic             w_any_req;
    logic             w_can_accept;
    logic             w_accept;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_ptr_next;

    assign w_any_req    = |REQ;
    assign w_can_accept = ~r_valid | RESULT_READY;
    assign w_accept     = w_can_accept & w_any_req & ~RESET;

    // Scan REQ starting at the pointer and wrapping modulo NREQ; the first
    // set bit encountered wins. The offset sum is reduced by one subtraction
    // since it never exceeds 2*NREQ-2, which keeps non-power-of-two NREQ
    // correct.
    always_comb begin
        int             v_pos;
        logic [IDW-1:0] v_idx;
        logic           v_found;
        w_winner = '0;
        v_found  = 1'b0;
        v_pos    = 0;
        v_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_pos = int'(r_ptr) + k;
            if (v_pos >= NREQ) begin
                v_pos = v_pos - NREQ;
            end
            v_idx = IDW'(v_pos);
            if (!v_found && REQ[v_idx]) begin
                v_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_ptr_next = (w_winner == c_LAST_ID) ? '0 : w_winner + 1'b1;

    always_comb begin
        GNT = '0;
        if (w_accept) begin
            GNT[w_winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Shared add/subtract datapath
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;

    assign w_a     = IN_A[w_winner*WIDTH +: WIDTH];
    assign w_b     = IN_B[w_winner*WIDTH +: WIDTH];
    assign w_sub   = SUB_ADD[w_winner];
    assign w_b_eff = w_sub ? ~w_b : w_b;

    // Subtraction is A + ~B + 1; its carry-out is the inverse of a borrow,
    // so XOR with the opcode yields carry for add and borrow for subtract.
    assign w_sum = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

    // ------------------------------------------------------------------------
    // Output stage and pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr        <= '0;
            r_result     <= '0;
            r_under_over <= 1'b0;
            r_result_id  <= '0;
            r_valid      <= 1'b0;
        end else if (w_accept) begin
            // A simultaneous consume is implied: the new result overwrites.
            r_result     <= w_sum[WIDTH-1:0];
            r_under_over <= w_sub ^ w_sum[WIDTH];
            r_result_id  <= w_winner;
            r_valid      <= 1'b1;
            r_ptr        <= w_ptr_next;
        end else if (RESULT_READY) begin
            // Consume with nothing new to accept; data fields hold.
            r_valid      <= 1'b0;
        end
    end

    assign RESULT       = r_result;
    assign UNDER_OVER   = r_under_over;
    assign RESULT_ID    = r_result_id;
    assign RESULT_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_arbiter
//  Purpose  : Self-checking bench for add_sub_arbiter: directed scenarios plus
//             randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sub_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       sub_add;
    logic [NREQ*WIDTH-1:0] in_a;
    logic [NREQ*WIDTH-1:0] in_b;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      result;
    logic                  under_over;
    logic [1:0]            result_id;
    logic                  result_valid;
    logic                  result_ready;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_res;
    logic       m_uo;
    logic [1:0] m_id;

    always #5 clk = ~clk;

    add_sub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .REQ          (req),
        .SUB_ADD      (sub_add),
        .IN_A         (in_a),
        .IN_B         (in_b),
        .GNT          (gnt),
        .RESULT       (result),
        .UNDER_OVER   (under_over),
        .RESULT_ID    (result_id),
        .RESULT_VALID (result_valid),
        .RESULT_READY (result_ready)
    );

    // First requesting index scanning from the model pointer, or -1.
    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        int w;
        w = pick();
        if (rst || (m_valid && !result_ready) || w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        int w, a, b;
        w = pick();
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_res = 8'h00; m_uo = 1'b0; m_id = 2'd0;
        end else if (!(m_valid && !result_ready) && w >= 0) begin
            a = int'(in_a[w*WIDTH +: WIDTH]);
            b = int'(in_b[w*WIDTH +: WIDTH]);
            if (sub_add[w]) begin
                m_res = 8'((a - b + 256) % 256);
                m_uo  = (a < b);
            end else begin
                m_res = 8'((a + b) % 256);
                m_uo  = (a + b) > 255;
            end
            m_id    = 2'(w);
            m_valid = 1'b1;
            m_ptr   = (w + 1) % NREQ;
        end else if (m_valid && result_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: edge, model update, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic s, input logic [7:0] a, input logic [7:0] b);
        sub_add[i]           = s;
        in_a[i*WIDTH +: WIDTH] = a;
        in_b[i*WIDTH +: WIDTH] = b;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        m_ptr = 0; m_valid = 1'b0; m_res = 8'h00; m_uo = 1'b0; m_id = 2'd0;
        rst = 1'b1; req = 4'b1111; result_ready = 1'b1;
        sub_add = '0; in_a = '0; in_b = '0;
        @(negedge clk);
        tick();
        tick();
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt: got %b expected 0000", gnt);
        end
        n_vec++;
        if ({result_valid, result, under_over, result_id} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_out: got v=%b r=%h uo=%b id=%0d expected all zero",
                     result_valid, result, under_over, result_id);
        end
        rst = 1'b0; req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_arith();
        int         idx [4] = '{0, 2, 2, 2};
        logic       s   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] a   [4] = '{8'h7F, 8'h10, 8'hFF, 8'h20};
        logic [7:0] b   [4] = '{8'h01, 8'h20, 8'h01, 8'h20};
        logic [7:0] er  [4] = '{8'h80, 8'hF0, 8'h00, 8'h00};
        logic       eu  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        result_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            set_op(idx[t], s[t], a[t], b[t]);
            req = 4'(1 << idx[t]);
            #1;
            n_vec++;
            if (gnt !== 4'(1 << idx[t])) begin
                n_err++;
                $display("FAIL arith_gnt[%0d]: got %b expected %b", t, gnt, 4'(1 << idx[t]));
            end
            tick();
            n_vec++;
            if ({result_valid, result, under_over, result_id} !== {1'b1, er[t], eu[t], 2'(idx[t])}) begin
                n_err++;
                $display("FAIL arith_out[%0d]: got v=%b r=%h uo=%b id=%0d expected v=1 r=%h uo=%b id=%0d",
                         t, result_valid, result, under_over, result_id, er[t], eu[t], idx[t]);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        int cnt [4] = '{0, 0, 0, 0};
        logic [3:0] eg;
        result_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i[0], 8'(8'h30 + i), 8'(8'h11 * i));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            eg = exp_gnt();
            n_vec++;
            if (gnt !== eg) begin
                n_err++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, eg);
            end
            for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) cnt[i]++;
            tick();
            n_vec++;
            if ({result_valid, result, under_over, result_id} !== {m_valid, m_res, m_uo, m_id}) begin
                n_err++;
                $display("FAIL rr_out[%0d]: got v=%b r=%h uo=%b id=%0d expected v=%b r=%h uo=%b id=%0d",
                         c, result_valid, result, under_over, result_id, m_valid, m_res, m_uo, m_id);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            n_vec++;
            if (cnt[i] != 2) begin
                n_err++;
                $display("FAIL rr_fair[%0d]: got %0d grants expected 2", i, cnt[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall();
        logic [11:0] snap;
        logic [3:0]  eg;
        snap = {m_valid, m_res, m_uo, m_id};
        req = 4'b1010; result_ready = 1'b0;
        set_op(1, 1'b0, 8'h05, 8'h06);
        set_op(3, 1'b1, 8'h01, 8'h02);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL stall_gnt[%0d]: got %b expected 0000", c, gnt);
            end
            tick();
            n_vec++;
            if ({result_valid, result, under_over, result_id} !== snap) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", c,
                         {result_valid, result, under_over, result_id}, snap);
            end
        end
        result_ready = 1'b1;
        #1;
        eg = exp_gnt();
        n_vec++;
        if (gnt !== eg) begin
            n_err++;
            $display("FAIL stall_release_gnt: got %b expected %b", gnt, eg);
        end
        tick();
        n_vec++;
        if ({result_valid, result, under_over, result_id} !== {m_valid, m_res, m_uo, m_id}) begin
            n_err++;
            $display("FAIL stall_release_out: got v=%b r=%h id=%0d expected v=%b r=%h id=%0d",
                     result_valid, result, result_id, m_valid, m_res, m_id);
        end
        req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        logic [3:0] seq_req [3] = '{4'b1000, 4'b1001, 4'b1001};
        logic [3:0] seq_gnt [3] = '{4'b1000, 4'b0001, 4'b1000};
        result_ready = 1'b1;
        set_op(0, 1'b0, 8'h80, 8'h80);
        set_op(3, 1'b1, 8'h00, 8'h01);
        for (int t = 0; t < 3; t++) begin
            req = seq_req[t];
            #1;
            n_vec++;
            if (gnt !== seq_gnt[t]) begin
                n_err++;
                $display("FAIL wrap_gnt[%0d]: got %b expected %b", t, gnt, seq_gnt[t]);
            end
            tick();
            n_vec++;
            if ({result_valid, result, under_over, result_id} !== {m_valid, m_res, m_uo, m_id}) begin
                n_err++;
                $display("FAIL wrap_out[%0d]: got v=%b r=%h uo=%b id=%0d expected v=%b r=%h uo=%b id=%0d",
                         t, result_valid, result, under_over, result_id, m_valid, m_res, m_uo, m_id);
            end
            if (t == 1) begin
                req = 4'b0000;
                for (int c = 0; c < 5; c++) tick();
                n_vec++;
                if (result_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL wrap_idle_valid: got %b expected 0", result_valid);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid();
        result_ready = 1'b1;
        req = 4'b1000;
        tick();
        rst = 1'b1; result_ready = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_gnt: got %b expected 0000", gnt);
        end
        tick();
        n_vec++;
        if ({result_valid, result, under_over, result_id} !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_out: got v=%b r=%h uo=%b id=%0d expected all zero",
                     result_valid, result, under_over, result_id);
        end
        rst = 1'b0; result_ready = 1'b1; req = 4'b1001;
        #1;
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL rstmid_after_gnt: got %b expected 0001", gnt);
        end
        tick();
        req = 4'b0000;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_random();
        logic [3:0] eg;
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 40) == 0);
            req          = 4'($urandom);
            result_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                set_op(i, 1'($urandom), 8'($urandom), 8'($urandom));
            #1;
            eg = exp_gnt();
            n_vec++;
            if (gnt !== eg) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, eg);
            end
            tick();
            n_vec++;
            if ({result_valid, result, under_over, result_id} !== {m_valid, m_res, m_uo, m_id}) begin
                n_err++;
                $display("FAIL rand_out[%0d]: got v=%b r=%h uo=%b id=%0d expected v=%b r=%h uo=%b id=%0d",
                         c, result_valid, result, under_over, result_id, m_valid, m_res, m_uo, m_id);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
